// File: rtl/classificador_temperatura_histerese_pkg.sv
// Shared definitions for the hysteresis temperature classifier:
// FSM state encoding and the binary16 field layout.
package classificador_temperatura_histerese_pkg;

  typedef enum logic [1:0] {
    INICIAL     = 2'd0,
    ESTAVEL     = 2'd1,
    CONFIRMANDO = 2'd2
  } estado_t;

  localparam logic [15:0] MASCARA_EXPOENTE = 16'h7C00;
  localparam int          BIT_SINAL        = 15;

  // An all-ones exponent encodes either infinity or NaN; neither is a usable reading.
  function automatic logic eh_nan_inf(input logic [15:0] amostra);
    return (amostra & MASCARA_EXPOENTE) == MASCARA_EXPOENTE;
  endfunction

endpackage

// File: rtl/classificador_temperatura_histerese_comparador.sv
// Combinational sign-magnitude float comparator (a versus b).
// +0 and -0 compare equal; magnitudes of negative values order in reverse.
module comparador_float_param
  import classificador_temperatura_histerese_pkg::*;
#(
  parameter int LARGURA = 16
) (
  input  logic [LARGURA-1:0] a,
  input  logic [LARGURA-1:0] b,
  output logic               gt,
  output logic               eq,
  output logic               lt
);

  localparam int POS_SINAL = (LARGURA == 16) ? BIT_SINAL : LARGURA - 1;

  logic               sinal_a;
  logic               sinal_b;
  logic [LARGURA-2:0] mag_a;
  logic [LARGURA-2:0] mag_b;

  assign sinal_a = a[POS_SINAL];
  assign sinal_b = b[POS_SINAL];
  assign mag_a   = a[LARGURA-2:0];
  assign mag_b   = b[LARGURA-2:0];

  // Resolve the ordering: zeros first, then sign, then magnitude (reversed when negative).
  always_comb begin
    gt = 1'b0;
    eq = 1'b0;
    lt = 1'b0;
    if (mag_a == '0 && mag_b == '0) begin
      eq = 1'b1;
    end else if (sinal_a != sinal_b) begin
      gt = sinal_b;
      lt = sinal_a;
    end else if (mag_a == mag_b) begin
      eq = 1'b1;
    end else begin
      gt = (mag_a > mag_b) ^ sinal_a;
      lt = ~gt;
    end
  end

endmodule

// File: rtl/classificador_temperatura_histerese.sv
// Classifies a stream of binary16 temperature samples into N_LIMIARES+1 levels
// with separate rising/falling limits and N-sample persistence. Two-stage pipeline:
// stage 1 counts limits crossed, stage 2 runs the confirmation FSM.
module classificador_temperatura_histerese
  import classificador_temperatura_histerese_pkg::*;
#(
  parameter  int LARGURA      = 16,
  parameter  int N_LIMIARES   = 3,
  parameter  int CONFIRMACOES = 3,
  localparam int LARG_NIVEL   = $clog2(N_LIMIARES + 1)
) (
  input  logic                          clock,
  input  logic                          reset,
  input  logic                          amostra_valida,
  input  logic [LARGURA-1:0]            temp,
  input  logic [N_LIMIARES*LARGURA-1:0] limiares_subida,
  input  logic [N_LIMIARES*LARGURA-1:0] limiares_descida,
  output logic [LARG_NIVEL-1:0]         nivel,
  output logic                          nivel_valido,
  output logic                          saida_valida,
  output logic                          mudou,
  output logic                          erro_amostra
);

  localparam int                  LARG_CONT = $clog2(CONFIRMACOES + 1);
  localparam logic [LARG_CONT-1:0] CONT_ALVO = LARG_CONT'(CONFIRMACOES);

  logic [N_LIMIARES-1:0] acima_sub;
  logic [N_LIMIARES-1:0] igual_sub;
  logic [N_LIMIARES-1:0] abaixo_sub;
  logic [N_LIMIARES-1:0] acima_desc;
  logic [N_LIMIARES-1:0] igual_desc;
  logic [N_LIMIARES-1:0] abaixo_desc;
  logic                  sinais_unused;

  logic [LARG_NIVEL-1:0] cnt_sub_c;
  logic [LARG_NIVEL-1:0] cnt_desc_c;

  logic                  s1_valida;
  logic                  s1_erro;
  logic [LARG_NIVEL-1:0] s1_cnt_sub;
  logic [LARG_NIVEL-1:0] s1_cnt_desc;

  estado_t               estado;
  estado_t               estado_prox;
  logic [LARG_NIVEL-1:0] pendente;
  logic [LARG_NIVEL-1:0] pendente_prox;
  logic [LARG_CONT-1:0]  contador;
  logic [LARG_CONT-1:0]  contador_prox;
  logic [LARG_CONT-1:0]  contador_inc;
  logic [LARG_NIVEL-1:0] nivel_prox;
  logic                  nivel_valido_prox;
  logic                  saida_valida_prox;
  logic                  mudou_prox;
  logic                  erro_prox;
  logic [LARG_NIVEL-1:0] candidato;

  for (genvar k = 0; k < N_LIMIARES; k++) begin : g_comparadores
    comparador_float_param #(.LARGURA(LARGURA)) u_cmp_sub (
      .a  (temp),
      .b  (limiares_subida[k*LARGURA +: LARGURA]),
      .gt (acima_sub[k]),
      .eq (igual_sub[k]),
      .lt (abaixo_sub[k])
    );
    comparador_float_param #(.LARGURA(LARGURA)) u_cmp_desc (
      .a  (temp),
      .b  (limiares_descida[k*LARGURA +: LARGURA]),
      .gt (acima_desc[k]),
      .eq (igual_desc[k]),
      .lt (abaixo_desc[k])
    );
  end

  // Only strict "greater than" matters for level counting.
  assign sinais_unused = ^{igual_sub, abaixo_sub, igual_desc, abaixo_desc};

  // Count how many rising and falling limits the current sample exceeds.
  always_comb begin
    cnt_sub_c  = '0;
    cnt_desc_c = '0;
    for (int k = 0; k < N_LIMIARES; k++) begin
      if (acima_sub[k])  cnt_sub_c  = cnt_sub_c  + LARG_NIVEL'(1);
      if (acima_desc[k]) cnt_desc_c = cnt_desc_c + LARG_NIVEL'(1);
    end
  end

  // Stage 1: capture the counts and error flag of each accepted sample.
  always_ff @(posedge clock) begin
    if (reset) begin
      s1_valida   <= 1'b0;
      s1_erro     <= 1'b0;
      s1_cnt_sub  <= '0;
      s1_cnt_desc <= '0;
    end else begin
      s1_valida <= amostra_valida;
      if (amostra_valida) begin
        s1_erro     <= eh_nan_inf(16'(temp));
        s1_cnt_sub  <= cnt_sub_c;
        s1_cnt_desc <= cnt_desc_c;
      end
    end
  end

  // Hysteresis: move up only past a rising limit, down only below a falling limit.
  always_comb begin
    candidato = nivel;
    if (s1_cnt_sub > nivel) begin
      candidato = s1_cnt_sub;
    end else if (s1_cnt_desc < nivel) begin
      candidato = s1_cnt_desc;
    end
  end

  assign contador_inc = contador + LARG_CONT'(1);

  // Stage 2 next-state: commit, start or continue confirming a level change.
  always_comb begin
    estado_prox       = estado;
    pendente_prox     = pendente;
    contador_prox     = contador;
    nivel_prox        = nivel;
    nivel_valido_prox = nivel_valido;
    saida_valida_prox = 1'b0;
    mudou_prox        = 1'b0;
    erro_prox         = 1'b0;

    if (s1_valida) begin
      saida_valida_prox = 1'b1;
      if (s1_erro) begin
        erro_prox     = 1'b1;
        contador_prox = '0;
        if (estado == CONFIRMANDO) estado_prox = ESTAVEL;
      end else begin
        unique case (estado)
          INICIAL: begin
            nivel_prox        = s1_cnt_sub;
            nivel_valido_prox = 1'b1;
            mudou_prox        = 1'b1;
            contador_prox     = '0;
            estado_prox       = ESTAVEL;
          end
          ESTAVEL: begin
            if (candidato != nivel) begin
              if (CONFIRMACOES == 1) begin
                nivel_prox    = candidato;
                mudou_prox    = 1'b1;
                contador_prox = '0;
              end else begin
                pendente_prox = candidato;
                contador_prox = LARG_CONT'(1);
                estado_prox   = CONFIRMANDO;
              end
            end
          end
          CONFIRMANDO: begin
            if (candidato == pendente) begin
              if (contador_inc == CONT_ALVO) begin
                nivel_prox    = pendente;
                mudou_prox    = 1'b1;
                contador_prox = '0;
                estado_prox   = ESTAVEL;
              end else begin
                contador_prox = contador_inc;
              end
            end else if (candidato == nivel) begin
              contador_prox = '0;
              estado_prox   = ESTAVEL;
            end else begin
              pendente_prox = candidato;
              contador_prox = LARG_CONT'(1);
            end
          end
          default: begin
            estado_prox   = INICIAL;
            contador_prox = '0;
          end
        endcase
      end
    end
  end

  // Stage 2 registers: FSM state, confirmation bookkeeping and all outputs.
  always_ff @(posedge clock) begin
    if (reset) begin
      estado       <= INICIAL;
      pendente     <= '0;
      contador     <= '0;
      nivel        <= '0;
      nivel_valido <= 1'b0;
      saida_valida <= 1'b0;
      mudou        <= 1'b0;
      erro_amostra <= 1'b0;
    end else begin
      estado       <= estado_prox;
      pendente     <= pendente_prox;
      contador     <= contador_prox;
      nivel        <= nivel_prox;
      nivel_valido <= nivel_valido_prox;
      saida_valida <= saida_valida_prox;
      mudou        <= mudou_prox;
      erro_amostra <= erro_prox;
    end
  end

endmodule

// File: tb/tb_classificador_temperatura_histerese.sv
// Scoreboard bench for the hysteresis temperature classifier: each driven sample
// pushes its hand-derived expected result, popped when saida_valida pulses.
module tb_classificador_temperatura_histerese;

  localparam int LARGURA    = 16;
  localparam int N_LIMIARES = 3;

  localparam logic [15:0] T25   = 16'h4E40;
  localparam logic [15:0] T30   = 16'h4F80;
  localparam logic [15:0] T32   = 16'h5000;
  localparam logic [15:0] T33   = 16'h5020;
  localparam logic [15:0] T34   = 16'h5040;
  localparam logic [15:0] T38   = 16'h50C0;
  localparam logic [15:0] T40   = 16'h5100;
  localparam logic [15:0] T45   = 16'h51A0;
  localparam logic [15:0] TNAN  = 16'h7E00;
  localparam logic [15:0] TM5   = 16'hC500;
  localparam logic [15:0] TM20  = 16'hCD00;
  localparam logic [15:0] TZERO = 16'h0000;

  typedef struct packed {
    logic [1:0] nivel;
    logic       nivel_valido;
    logic       mudou;
    logic       erro;
  } esperado_t;

  logic                          clock;
  logic                          reset;
  logic                          amostra_valida;
  logic [LARGURA-1:0]            temp;
  logic [N_LIMIARES*LARGURA-1:0] limiares_subida;
  logic [N_LIMIARES*LARGURA-1:0] limiares_descida;
  logic [1:0]                    nivel;
  logic                          nivel_valido;
  logic                          saida_valida;
  logic                          mudou;
  logic                          erro_amostra;

  esperado_t fila[$];
  esperado_t atual;
  int        comparacoes = 0;
  int        falhas      = 0;

  classificador_temperatura_histerese #(
    .LARGURA      (LARGURA),
    .N_LIMIARES   (N_LIMIARES),
    .CONFIRMACOES (3)
  ) dut (
    .clock            (clock),
    .reset            (reset),
    .amostra_valida   (amostra_valida),
    .temp             (temp),
    .limiares_subida  (limiares_subida),
    .limiares_descida (limiares_descida),
    .nivel            (nivel),
    .nivel_valido     (nivel_valido),
    .saida_valida     (saida_valida),
    .mudou            (mudou),
    .erro_amostra     (erro_amostra)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic checkOutput(input string tag, input logic [31:0] observado,
                             input logic [31:0] esperado);
    comparacoes++;
    if (observado !== esperado) begin
      falhas++;
      $display("[TB] FAIL %s: observed %0d, expected %0d", tag, observado, esperado);
    end
  endtask

  task automatic applyStimulus(input logic [15:0] valor, input logic [1:0] nivel_esp,
                               input logic nv_esp, input logic mudou_esp,
                               input logic erro_esp);
    @(posedge clock);
    #1;
    amostra_valida = 1'b1;
    temp           = valor;
    fila.push_back('{nivel: nivel_esp, nivel_valido: nv_esp, mudou: mudou_esp, erro: erro_esp});
  endtask

  task automatic drain();
    int ciclos = 0;
    @(posedge clock);
    #1;
    amostra_valida = 1'b0;
    while (fila.size() != 0 && ciclos < 10) begin
      @(negedge clock);
      ciclos++;
    end
    checkOutput("fila_esvaziada", fila.size(), 0);
  endtask

  task automatic pulseReset();
    @(posedge clock);
    #1;
    reset          = 1'b1;
    amostra_valida = 1'b0;
    @(posedge clock);
    #1;
    checkOutput("reset_nivel", nivel, 0);
    checkOutput("reset_nivel_valido", nivel_valido, 0);
    checkOutput("reset_saida_valida", saida_valida, 0);
    checkOutput("reset_mudou", mudou, 0);
    checkOutput("reset_erro", erro_amostra, 0);
    reset = 1'b0;
  endtask

  // Compare every produced result against the oldest expectation; no pulse may appear otherwise.
  always @(negedge clock) begin
    if (saida_valida) begin
      if (fila.size() == 0) begin
        checkOutput("pulso_inesperado", 1, 0);
      end else begin
        atual = fila.pop_front();
        checkOutput("nivel", nivel, atual.nivel);
        checkOutput("nivel_valido", nivel_valido, atual.nivel_valido);
        checkOutput("mudou", mudou, atual.mudou);
        checkOutput("erro_amostra", erro_amostra, atual.erro);
      end
    end else begin
      checkOutput("pulso_sem_saida", {mudou, erro_amostra}, 0);
    end
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    reset            = 1'b1;
    amostra_valida   = 1'b0;
    temp             = '0;
    limiares_subida  = {16'h5100, 16'h5060, 16'h4F80};
    limiares_descida = {16'h50C0, 16'h5020, 16'h4F00};
    pulseReset();

    // First valid sample commits immediately: 33 exceeds only the 30 rising limit.
    applyStimulus(T33, 2'd1, 1'b1, 1'b1, 1'b0);
    drain();

    // Three consecutive 38s confirm level 2.
    applyStimulus(T38, 2'd1, 1'b1, 1'b0, 1'b0);
    applyStimulus(T38, 2'd1, 1'b1, 1'b0, 1'b0);
    applyStimulus(T38, 2'd2, 1'b1, 1'b1, 1'b0);
    drain();

    // 34 sits inside the hysteresis band of level 2; 32 falls below 33 and confirms level 1.
    for (int i = 0; i < 5; i++) applyStimulus(T34, 2'd2, 1'b1, 1'b0, 1'b0);
    applyStimulus(T32, 2'd2, 1'b1, 1'b0, 1'b0);
    applyStimulus(T32, 2'd2, 1'b1, 1'b0, 1'b0);
    applyStimulus(T32, 2'd1, 1'b1, 1'b1, 1'b0);
    drain();

    // The 34 matches the committed level and restarts confirmation; the third 38 after it commits.
    applyStimulus(T38, 2'd1, 1'b1, 1'b0, 1'b0);
    applyStimulus(T38, 2'd1, 1'b1, 1'b0, 1'b0);
    applyStimulus(T34, 2'd1, 1'b1, 1'b0, 1'b0);
    applyStimulus(T38, 2'd1, 1'b1, 1'b0, 1'b0);
    applyStimulus(T38, 2'd1, 1'b1, 1'b0, 1'b0);
    applyStimulus(T38, 2'd2, 1'b1, 1'b1, 1'b0);
    drain();

    // Back to level 1, then a NaN between 38s clears the confirmation count.
    applyStimulus(T32, 2'd2, 1'b1, 1'b0, 1'b0);
    applyStimulus(T32, 2'd2, 1'b1, 1'b0, 1'b0);
    applyStimulus(T32, 2'd1, 1'b1, 1'b1, 1'b0);
    applyStimulus(T38, 2'd1, 1'b1, 1'b0, 1'b0);
    applyStimulus(TNAN, 2'd1, 1'b1, 1'b0, 1'b1);
    applyStimulus(T38, 2'd1, 1'b1, 1'b0, 1'b0);
    applyStimulus(T38, 2'd1, 1'b1, 1'b0, 1'b0);
    applyStimulus(T38, 2'd2, 1'b1, 1'b1, 1'b0);
    drain();

    // From INICIAL a NaN commits nothing; -5 then commits level 0.
    pulseReset();
    applyStimulus(TNAN, 2'd0, 1'b0, 1'b0, 1'b1);
    applyStimulus(TM5, 2'd0, 1'b1, 1'b1, 1'b0);
    drain();

    // Samples equal to a limit do not exceed it.
    pulseReset();
    applyStimulus(T45, 2'd3, 1'b1, 1'b1, 1'b0);
    applyStimulus(T40, 2'd3, 1'b1, 1'b0, 1'b0);
    applyStimulus(T30, 2'd3, 1'b1, 1'b0, 1'b0);
    applyStimulus(T30, 2'd3, 1'b1, 1'b0, 1'b0);
    applyStimulus(T30, 2'd1, 1'b1, 1'b1, 1'b0);
    drain();

    // Reset while confirming, then a fresh first sample.
    pulseReset();
    applyStimulus(T33, 2'd1, 1'b1, 1'b1, 1'b0);
    applyStimulus(T38, 2'd1, 1'b1, 1'b0, 1'b0);
    applyStimulus(T38, 2'd1, 1'b1, 1'b0, 1'b0);
    drain();
    pulseReset();
    applyStimulus(T25, 2'd0, 1'b1, 1'b1, 1'b0);
    drain();

    // A sample still in stage 1 when reset arrives must vanish.
    pulseReset();
    @(posedge clock);
    #1;
    amostra_valida = 1'b1;
    temp           = T33;
    @(posedge clock);
    #1;
    amostra_valida = 1'b0;
    reset          = 1'b1;
    @(posedge clock);
    #1;
    reset = 1'b0;
    repeat (4) @(posedge clock);
    #1;
    checkOutput("descartada_nivel_valido", nivel_valido, 0);

    // Signed limits: -10, -0, 30 rising; -12, -1, 28 falling.
    limiares_subida  = {16'h4F80, 16'h8000, 16'hC900};
    limiares_descida = {16'h4F00, 16'hBC00, 16'hCA00};
    pulseReset();
    applyStimulus(TZERO, 2'd1, 1'b1, 1'b1, 1'b0);
    applyStimulus(TM20, 2'd1, 1'b1, 1'b0, 1'b0);
    applyStimulus(TM20, 2'd1, 1'b1, 1'b0, 1'b0);
    applyStimulus(TM20, 2'd0, 1'b1, 1'b1, 1'b0);
    drain();
    pulseReset();
    applyStimulus(TM5, 2'd1, 1'b1, 1'b1, 1'b0);
    drain();

    repeat (2) @(posedge clock);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", comparacoes, falhas);
    $finish;
  end

endmodule
